keypad_seq_in: RTL and testbench

Matrix-keypad scanner that produces the hex digit sequence consumed by the seven-segment marquee path. It drives the rows of a 4x4 keypad, samples and debounces the columns, decodes one pressed key into a 4-bit code, and shifts accepted codes into an N-bit sequence register. It is the input end of the display pipeline: its `seq` output connects directly to the marquee's `seq` input.

---
 rtl/keypad_seq_in.sv | 165 ++++++++++++++++
 tb/tb_keypad_seq_in.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_seq_in.sv
// keypad_seq_in: 4x4 keypad row scanner, debouncer and hex-digit shift register.
// Defining KEYPAD_REPEAT_EN adds auto-repeat while a key is held.
module keypad_seq_in #(
  parameter int N            = 32,
  parameter int WIDTH        = 4,
  parameter int SCAN_DIV     = 50_000,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_SCANS = 100
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic [3:0]                     col,
  input  logic                           clear,
  output logic [3:0]                     row,
  output logic [3:0]                     key_code,
  output logic                           key_valid,
  output logic [$clog2(N/WIDTH+1)-1:0]   digits,
  output logic [N-1:0]                   seq
);
  localparam int DW = $clog2(N / WIDTH + 1);
  localparam int VW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DMAX  = DW'(N / WIDTH);
  localparam logic [VW-1:0] VLAST = VW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB    = CW'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, REL} state_t;

  if (SCAN_DIV < 4 || DEBOUNCE < 1 || REPEAT_SCANS < 1 || WIDTH != 4 || N % WIDTH != 0) begin : g_bad
    $error("keypad_seq_in: unsupported parameters");
  end

  logic [3:0]    col_s1, col_s2;
  logic [VW-1:0] div;
  logic [1:0]    r;
  logic [15:0]   snap, snap_nx;
  logic          tc, scan_done, single, rel;
  logic [3:0]    code;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    cand, cand_nx;
  logic          fsm_acc, rep_hit, acc;

  assign tc        = div == VLAST;
  assign scan_done = tc && r == 2'd3;
  assign acc       = fsm_acc | rep_hit;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_s1 <= '1;
      col_s2 <= '1;
      div    <= '0;
      r      <= '0;
      row    <= 4'b1110;
      snap   <= '0;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
      div    <= tc ? '0 : div + 1'b1;
      if (tc) begin
        r    <= r + 1'b1;
        row  <= {row[2:0], row[3]};
        snap <= snap_nx;
      end
    end
  end

  // snap_nx is the snapshot including the row being sampled this cycle
  always_comb begin
    snap_nx = snap;
    snap_nx[{r, 2'b00} +: 4] = ~col_s2;
    code = '0;
    for (int k = 0; k < 16; k++)
      if (snap_nx[k]) code = 4'(k);
    rel    = snap_nx == 16'd0;
    single = !rel && (snap_nx & (snap_nx - 16'd1)) == 16'd0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cand  <= cand_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    fsm_acc  = 1'b0;
    if (scan_done) begin
      case (state)
        IDLE: if (single) begin
          cand_nx  = code;
          cnt_nx   = CW'(1);
          fsm_acc  = DEBOUNCE == 1;
          state_nx = DEBOUNCE == 1 ? HELD : PRESS;
        end
        PRESS: if (single && code == cand) begin
          cnt_nx   = cnt + 1'b1;
          fsm_acc  = cnt_nx == DB;
          state_nx = fsm_acc ? HELD : PRESS;
        end else state_nx = IDLE;
        HELD: if (rel) begin
          cnt_nx   = CW'(1);
          state_nx = DEBOUNCE == 1 ? IDLE : REL;
        end
        REL: if (rel) begin
          cnt_nx   = cnt + 1'b1;
          state_nx = cnt_nx == DB ? IDLE : REL;
        end else state_nx = HELD;
        default: state_nx = IDLE;
      endcase
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] RMAX = RW'(REPEAT_SCANS);
  logic [RW-1:0] rep, rep_nx;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rep <= '0;
    else rep <= rep_nx;
  end

  // multi-key snapshots while held neither advance nor reset the repeat count
  always_comb begin
    rep_nx  = rep;
    rep_hit = 1'b0;
    if (scan_done) begin
      if (state == HELD && single && code == cand) begin
        rep_hit = rep == RMAX - 1'b1;
        rep_nx  = rep_hit ? '0 : rep + 1'b1;
      end else if (state != HELD || rel || single) rep_nx = '0;
    end
  end
`else
  assign rep_hit = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      digits    <= '0;
      seq       <= '0;
    end else begin
      key_valid <= acc;
      if (acc) key_code <= cand_nx;
      if (clear) begin
        seq    <= '0;
        digits <= '0;
      end else if (acc) begin
        seq    <= {seq[N-WIDTH-1:0], cand_nx};
        digits <= digits == DMAX ? digits : digits + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_keypad_seq_in.sv
// tb_keypad_seq_in: scan-level keypad stimulus checked against a run-length debounce model.
module tb_keypad_seq_in;
  localparam int DB = 3;
  localparam int RS = 5;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  col, row, key_code;
  logic        key_valid;
  logic [3:0]  digits;
  logic [31:0] seq;
  logic [15:0] pressed = '0;

  int total = 0, passed = 0, fails = 0, n_acc = 0;
  bit armed = 1'b1;
  int run = 0, zrun = 0, rep = 0, last = 0, m_dig = 0;
  logic [31:0] m_seq = '0;

  keypad_seq_in #(.N(32), .WIDTH(4), .SCAN_DIV(4), .DEBOUNCE(DB), .REPEAT_SCANS(RS)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .col(col), .clear(clear), .row(row),
    .key_code(key_code), .key_valid(key_valid), .digits(digits), .seq(seq)
  );

  always #5 sys_clk = ~sys_clk;

  // physical keypad: a pressed key shorts its column to a driven-low row
  always_comb begin
    col = 4'hF;
    for (int i = 0; i < 4; i++)
      if (!row[i]) col = col & ~pressed[4*i +: 4];
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    armed = 1'b1; run = 0; zrun = 0; rep = 0; m_seq = '0; m_dig = 0;
  endtask

  // accept after DB identical one-key scans; re-arm after DB empty scans
  task automatic model_step(input logic [15:0] s, input bit clr, output bit acc);
    int k;
    bit single;
    single = $countones(s) == 1;
    k = -1;
    for (int i = 0; i < 16; i++) if (s[i]) k = i;
    acc = 1'b0;
    if (armed) begin
      if (single && run > 0 && k == last) run++;
      else if (single && run == 0) begin last = k; run = 1; end
      else run = 0;
      if (run == DB) begin acc = 1'b1; armed = 1'b0; zrun = 0; rep = 0; run = 0; end
    end else if (s == 0) begin
      rep = 0;
      zrun++;
      if (zrun == DB) begin armed = 1'b1; run = 0; end
    end else if (zrun > 0) zrun = 0;
`ifdef KEYPAD_REPEAT_EN
    else if (single && k == last) begin
      rep++;
      if (rep == RS) begin acc = 1'b1; rep = 0; end
    end else if (single) rep = 0;
`endif
    if (clr) begin
      m_seq = '0; m_dig = 0;
    end else if (acc) begin
      m_seq = {m_seq[27:0], 4'(last)};
      m_dig = m_dig < 8 ? m_dig + 1 : 8;
    end
  endtask

  // one full 16-cycle scan holding mask s; optional clear during its final cycle
  task automatic scan(input logic [15:0] s, input bit clr = 1'b0);
    bit acc;
    model_step(s, clr, acc);
    pressed = s;
    for (int i = 1; i <= 16; i++) begin
      @(negedge sys_clk);
      chk("row", {28'd0, row}, {28'd0, ~(4'b0001 << ((i / 4) % 4))});
      chk("key_valid", {31'd0, key_valid}, {31'd0, i == 16 && acc});
      if (key_valid) n_acc++;
      if (i == 15) clear = clr;
      if (i == 16) begin
        chk("seq", seq, m_seq);
        chk("digits", {28'd0, digits}, m_dig);
        if (acc) chk("key_code", {28'd0, key_code}, last);
        clear = 1'b0;
      end
    end
  endtask

  initial begin
    int a, len, fav, b;
    logic [15:0] m;
    bit clr;
    repeat (2) @(negedge sys_clk);
    chk("rst_row", {28'd0, row}, 32'hE);
    chk("rst_seq", seq, 0);
    chk("rst_digits", {28'd0, digits}, 0);
    chk("rst_valid", {31'd0, key_valid}, 0);
    chk("rst_code", {28'd0, key_code}, 0);
    sys_rst_n = 1'b1;
    model_reset();

    a = n_acc;
    repeat (5) scan(16'h0200);
    chk("single_accepts", n_acc - a, 1);
    chk("single_code", {28'd0, key_code}, 32'h9);
    chk("single_seq", seq, 32'h0000_0009);
    chk("single_digits", {28'd0, digits}, 1);
    repeat (3) scan(16'h0000);

    a = n_acc;
    repeat (3) begin
      repeat (2) scan(16'h0001);
      repeat (2) scan(16'h0000);
    end
    chk("bounce_accepts", n_acc - a, 0);
    repeat (4) scan(16'h0021);
    chk("multi_accepts", n_acc - a, 0);
    repeat (3) scan(16'h0001);
    repeat (3) scan(16'h0021);
    chk("held_multi_accepts", n_acc - a, 1);
    repeat (3) scan(16'h0000);

    scan(16'h0000, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      repeat (3) scan(16'h0001 << k);
      repeat (3) scan(16'h0000);
      if (k == 8) chk("digits_full", {28'd0, digits}, 8);
    end
    chk("sat_seq", seq, 32'h2345_6789);
    chk("sat_digits", {28'd0, digits}, 8);

    scan(16'h0010);
    scan(16'h0010);
    scan(16'h0010, 1'b1);
    chk("clr_valid", {31'd0, key_valid}, 1);
    chk("clr_code", {28'd0, key_code}, 4);
    chk("clr_seq", seq, 0);
    chk("clr_digits", {28'd0, digits}, 0);
    repeat (3) scan(16'h0000);

    a = n_acc;
    repeat (13) scan(16'h8000);
`ifdef KEYPAD_REPEAT_EN
    chk("repeat_accepts", n_acc - a, 3);
    chk("repeat_seq", {20'd0, seq[11:0]}, 32'hFFF);
`else
    chk("repeat_accepts", n_acc - a, 1);
`endif
    repeat (3) scan(16'h0000);

    repeat (2) scan(16'h0080);
    repeat (6) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_row", {28'd0, row}, 32'hE);
    chk("async_seq", seq, 0);
    chk("async_digits", {28'd0, digits}, 0);
    chk("async_valid", {31'd0, key_valid}, 0);
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    a = n_acc;
    repeat (2) scan(16'h0080);
    chk("redebounce_none", n_acc - a, 0);
    scan(16'h0080);
    chk("redebounce_one", n_acc - a, 1);
    chk("redebounce_code", {28'd0, key_code}, 7);
    repeat (3) scan(16'h0000);

    repeat (30) begin
      len = $urandom_range(1, 6);
      fav = $urandom_range(0, 15);
      b = (fav + 1 + $urandom_range(0, 14)) % 16;
      case ($urandom_range(0, 9))
        0, 1, 2: m = 16'h0000;
        9:       m = (16'h0001 << fav) | (16'h0001 << b);
        default: m = 16'h0001 << fav;
      endcase
      repeat (len) begin
        clr = $urandom_range(0, 19) == 0;
        scan(m, clr);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
